// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux, with a registered one-hot grant.
// Optional hold limit (MAX_HOLD cycles while others wait) is built when MUX_HOLD_LIMIT_EN is defined.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;

    logic [3:0] others;
    logic       owner_req;
    logic [2:0] pick_idle;
    logic [2:0] pick_next;
    logic       take;
    logic [1:0] take_idx;

    // Returns {found, index}; search order is base+1, base+2, base+3, base (mod 4).
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] mask);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign others    = req & ~gnt_q;
    assign owner_req = |(req & gnt_q);
    assign pick_idle = rr_pick(last_q, req);
    assign pick_next = rr_pick(sel_q, others);

`ifdef MUX_HOLD_LIMIT_EN
    localparam int         HOLD_LIM = (MAX_HOLD < 2) ? 2 : ((MAX_HOLD > 255) ? 255 : MAX_HOLD);
    localparam logic [7:0] HOLD_TC  = 8'(HOLD_LIM - 1);

    logic [7:0] hold_q, hold_d;
    logic       hold_expired;

    assign hold_expired = (hold_q >= HOLD_TC);
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        take     = 1'b0;
        take_idx = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (pick_idle[2]) begin
                    take     = 1'b1;
                    take_idx = pick_idle[1:0];
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    if (pick_next[2]) begin
                        take     = 1'b1;
                        take_idx = pick_next[1:0];
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                    end
`ifdef MUX_HOLD_LIMIT_EN
                end else if (hold_expired && pick_next[2]) begin
                    // Forced rotation: the still-requesting owner drops to lowest priority.
                    take     = 1'b1;
                    take_idx = pick_next[1:0];
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        if (take) begin
            state_d = ST_OWN;
            gnt_d   = 4'b0001 << take_idx;
            sel_d   = take_idx;
            last_d  = take_idx;
        end
    end

`ifdef MUX_HOLD_LIMIT_EN
    always_comb begin
        hold_d = hold_q;
        if (take || (state_d == ST_IDLE)) begin
            hold_d = 8'd0;
        end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q == ST_OWN);

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 gate-level multiplexer between four requesters. It owns the mux select lines `s1`/`s0` and returns a one-hot grant, so only the granted source's data reaches the shared mux output. The block sits directly in front of the mux select pins, and each requester's `i*` data line feeds the mux unchanged.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold the mux while others wait. Legal range 2..255. Used only when `MUX_HOLD_LIMIT_EN` is defined.

Ports:
- `clk`  input  1  — single clock, rising edge.
- `reset`  input  1  — asynchronous, active-high reset.
- `req`  input  4  — level request; bit n belongs to requester n (mux input `in`).
- `gnt`  output  4  — one-hot grant, registered; all-zero when idle.
- `s1`  output  1  — mux select MSB, registered.
- `s0`  output  1  — mux select LSB, registered.
- `busy`  output  1  — high while any grant is active; equals `|gnt`.

## Operation
- Two states:
  - IDLE: `gnt`=0.
  - OWN: exactly one `gnt` bit is set.
- Round-robin pointer `last` (2 bits) holds the index of the most recent grantee. The search order is `last+1`, `last+2`, `last+3`, `last`, all mod 4 (wrap-around 3→0).
- IDLE → OWN: at the clock edge where `req`≠0, grant the first requester in search order. Set `last` and `{s1,s0}` to its index.
- OWN, owner's `req` still high: hold the grant. `gnt`, `s1` and `s0` stay stable.
- OWN, owner's `req` low at the edge:
  - If other requests are pending, hand off at the same edge to the next requester in search order from the old owner. No bubble cycle.
  - Otherwise go to IDLE.
- Release and new request in the same cycle: the new request is arbitrated at that edge (simultaneous event, no lost cycle).
- `{s1,s0}` keeps the last granted index while IDLE. The mux output is don't-care when `busy`=0.
- `gnt` is never multi-hot. `{s1,s0}` always matches the set `gnt` bit while `busy`=1.
- A requester dropping `req` while not granted is simply ignored; there is no latching of requests.

## Timing
- Reset values: `gnt`=4'b0000, `s1`=0, `s0`=0, `busy`=0, `last`=2'd3 (so requester 0 wins first), hold counter=0.
- Reset is asynchronous. Asserting it mid-grant clears all outputs immediately, without waiting for a clock edge. The first arbitration occurs at the first rising edge after `reset` deasserts.
- Grant latency: `req` high before edge k → `gnt`/`s1`/`s0` valid after edge k (1 cycle).
- Release latency: owner `req` low before edge k → grant moves or clears after edge k.
- All outputs come directly from flops, with no combinational path from `req` to outputs.

## Configuration
- `MUX_HOLD_LIMIT_EN` defined:
  - An 8-bit hold counter increments each cycle in OWN and clears on every grant change.
  - When the counter reaches `MAX_HOLD`−1 and any other `req` bit is set, the grant is forcibly moved at that edge to the next requester in search order. The ex-owner, still requesting, rejoins the rotation as lowest priority.
  - With no other requester pending, the owner keeps the mux indefinitely and the counter saturates.
- `MUX_HOLD_LIMIT_EN` not defined:
  - No counter is built.
  - An owner holds the mux for as long as its `req` stays high.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset then single request: `req`=4'b0100 → after 1 edge `gnt`=4'b0100, `{s1,s0}`=2'b10, `busy`=1. After `req`=0 → next edge `gnt`=0, `{s1,s0}` stays 2'b10.
- All request out of reset: `req`=4'b1111, each owner drops `req` for one cycle after 2 cycles of ownership then reasserts → grants rotate 0,1,2,3,0 with no idle cycle between owners.
- Wrap-around priority: grant 3, then `req`=4'b1001 when 3 releases → `gnt`=4'b0001 (0 beats 3).
- Async reset mid-grant: `gnt`=4'b0010, assert `reset` between edges → `gnt`=0, `s1`=`s0`=0 before the next edge. After release with `req`=4'b0010 → `gnt`=4'b0010 one edge later.
- `MUX_HOLD_LIMIT_EN`, `MAX_HOLD`=4: `req`=4'b0011 held constant → `gnt` alternates 0001 for 4 cycles, then 0010 for 4 cycles, then 0001 for 4 cycles.
- `MUX_HOLD_LIMIT_EN`, `MAX_HOLD`=4, only `req`=4'b0001 for 20 cycles → `gnt`=4'b0001 throughout, never dropped.
